// File: rtl/counter.sv
// Multi-digit BCD up/down counter; each step takes COUNT_DELAY clocks,
// mimicking the slow stepping of a dekatron digit chain.
module counter #(
  parameter int D_NUM       = 6,
  parameter int COUNT_DELAY = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_request,
  input  logic               i_dec,
  input  logic               i_set,
  input  logic [4*D_NUM-1:0] i_in,
  output logic               o_ready,
  output logic [4*D_NUM-1:0] o_out
);

  localparam int W = 4 * D_NUM;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         r_state;
  logic [7:0]     r_cnt;
  logic           r_dec;
  logic [W-1:0]   r_out;

  state_t         w_state_nxt;
  logic [7:0]     w_cnt_nxt;
  logic           w_dec_nxt;
  logic [W-1:0]   w_out_nxt;
  logic [W-1:0]   w_load;
  logic [W-1:0]   w_up;
  logic [W-1:0]   w_dn;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         carry;
    logic [3:0]   d;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < D_NUM; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (d >= 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = d + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         borrow;
    logic [3:0]   d;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < D_NUM; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = d - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // Non-decimal load digits are forced to 0 so Out is always valid BCD.
  always_comb begin
    w_load = '0;
    for (int i = 0; i < D_NUM; i++) begin
      if (i_in[4*i +: 4] <= 4'd9) w_load[4*i +: 4] = i_in[4*i +: 4];
    end
  end

  assign w_up = bcd_inc(r_out);
  assign w_dn = bcd_dec(r_out);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dec_nxt   = r_dec;
    w_out_nxt   = r_out;
    if (i_set) begin
      w_out_nxt   = w_load;
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_request) begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = 8'(COUNT_DELAY - 1);
            w_dec_nxt   = i_dec;
          end
        end
        BUSY: begin
          if (r_cnt != 8'd0) begin
            w_cnt_nxt = r_cnt - 8'd1;
          end else begin
            w_out_nxt   = r_dec ? w_dn : w_up;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dec   <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dec   <= w_dec_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign o_ready = (r_state == IDLE);
  assign o_out   = r_out;

endmodule

// File: tb/tb_counter.sv
// Directed bench for the BCD counter: latency, carry/borrow, load and priority.
module tb_counter;

  localparam int D_NUM = 6;
  localparam int W     = 4 * D_NUM;

  logic         clk;
  logic         rst;
  logic         request;
  logic         dec;
  logic         set;
  logic [W-1:0] din;
  logic         ready;
  logic [W-1:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  counter #(.D_NUM(D_NUM), .COUNT_DELAY(3)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_request (request),
    .i_dec     (dec),
    .i_set     (set),
    .i_in      (din),
    .o_ready   (ready),
    .o_out     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [W-1:0] v);
    set = 1'b1;
    din = v;
    tick();
    set = 1'b0;
  endtask

  // One request pulse, then wait (bounded) for completion.
  task automatic step(input logic d, input string tag);
    int waited;
    request = 1'b1;
    dec     = d;
    tick();
    request = 1'b0;
    waited  = 0;
    while (!ready && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_done"}, W'(ready), W'(1));
  endtask

  initial begin
    rst = 1'b1; request = 1'b0; dec = 1'b0; set = 1'b0; din = '0;
    tick(2);
    rst = 1'b0;
    chk("rst_out", dout, 24'h000000);
    chk("rst_ready", W'(ready), W'(1));
    tick(3);
    chk("idle_out", dout, 24'h000000);

    // Latency: request accepted at edge k, result after edge k+3.
    request = 1'b1; dec = 1'b0;
    tick();
    chk("lat_k_ready", W'(ready), W'(0));
    tick();
    chk("lat_k1_ready", W'(ready), W'(0));
    chk("lat_k1_out", dout, 24'h000000);
    tick();
    chk("lat_k2_ready", W'(ready), W'(0));
    chk("lat_k2_out", dout, 24'h000000);
    request = 1'b0;
    tick();
    chk("lat_k3_ready", W'(ready), W'(1));
    chk("lat_k3_out", dout, 24'h000001);
    tick();
    chk("lat_hold_out", dout, 24'h000001);

    // Round trip with Request held high: one step per 4 clocks.
    load(24'h000000);
    request = 1'b1; dec = 1'b0;
    tick(200);
    request = 1'b0;
    chk("up50_out", dout, 24'h000050);
    chk("up50_ready", W'(ready), W'(1));
    request = 1'b1; dec = 1'b1;
    tick(200);
    request = 1'b0;
    chk("dn50_out", dout, 24'h000000);

    // Carry, borrow and wrap.
    load(24'h000099);
    chk("set99", dout, 24'h000099);
    step(1'b0, "c99");
    chk("carry_99", dout, 24'h000100);
    load(24'h999999);
    step(1'b0, "c9s");
    chk("wrap_up", dout, 24'h000000);
    step(1'b1, "b0s");
    chk("wrap_dn", dout, 24'h999999);
    load(24'h001000);
    step(1'b1, "b1000");
    chk("borrow_1000", dout, 24'h000999);

    // Load then 39 down steps.
    load(24'h000039);
    chk("set39", dout, 24'h000039);
    request = 1'b1; dec = 1'b1;
    tick(156);
    request = 1'b0;
    chk("dn39_out", dout, 24'h000000);
    load(24'h00001A);
    chk("set_1A", dout, 24'h000010);

    // Set aborts a pending step.
    load(24'h000007);
    request = 1'b1; dec = 1'b0;
    tick();
    request = 1'b0;
    tick();
    chk("abort_busy", W'(ready), W'(0));
    load(24'h000500);
    chk("abort_out", dout, 24'h000500);
    chk("abort_ready", W'(ready), W'(1));
    tick(4);
    chk("abort_nostep", dout, 24'h000500);

    // Set and Request on the same edge: load only.
    request = 1'b1; set = 1'b1; din = 24'h000123;
    tick();
    request = 1'b0; set = 1'b0;
    chk("prio_out", dout, 24'h000123);
    chk("prio_ready", W'(ready), W'(1));
    tick(4);
    chk("prio_nostep", dout, 24'h000123);

    // Reset during BUSY.
    request = 1'b1; dec = 1'b0;
    tick();
    request = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstbusy_out", dout, 24'h000000);
    chk("rstbusy_ready", W'(ready), W'(1));
    tick(4);
    chk("rstbusy_hold", dout, 24'h000000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/counter.md
Name: counter

Overview:
- Multi-digit BCD up/down counter with a request/ready handshake.
- Each counting step takes a fixed, parameterised number of clocks, modelling the slow stepping of a dekatron digit chain.
- Supports a parallel load.
- Used as a generic address/data counter in the dekatron processor datapath.

Parameters:
- D_NUM, 6: number of BCD decades; Out/In width = 4*D_NUM.
- COUNT_DELAY, 3: clocks from an accepted Request to the updated Out with Ready high again; legal range 1..255.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Rst  input  1  synchronous reset, active-high.
- Request  input  1  count-step request; sampled only while Ready=1.
- Dec  input  1  step direction, sampled with Request: 0 = +1, 1 = -1.
- Set  input  1  synchronous parallel load of In.
- In  input  4*D_NUM  load value; BCD, digit i in bits [4i+3:4i], digit 0 least significant.
- Ready  output  1  1 = idle and able to accept a Request.
- Out  output  4*D_NUM  current count, BCD, same digit layout as In.

Behaviour:
- Reset (Rst=1 at a rising edge): Out=0, Ready=1, state=IDLE, delay counter=0. Rst overrides Set and Request.
- FSM states: IDLE (Ready=1) and BUSY (Ready=0).
- IDLE with Request=1 and Set=0 at an edge:
  - Latch Dec.
  - Go to BUSY; Ready=0 from the next cycle.
  - Load the delay counter with COUNT_DELAY-1.
- BUSY, each edge:
  - If the delay counter is nonzero, decrement it.
  - If it is zero, apply the step to Out, set Ready=1, return to IDLE.
- Latency: Request accepted at edge k gives new Out and Ready=1 visible after edge k+COUNT_DELAY.
  - COUNT_DELAY=1: Ready is low for exactly one cycle.
  - A Request held high continuously is accepted again at the first edge where Ready=1, giving one step per COUNT_DELAY+1 clocks.
- Request while BUSY is ignored; no queueing. Dec changes while BUSY have no effect.
- Out is stable throughout BUSY and changes only on the completing edge or on Set.
- Arithmetic: decimal, per digit 0..9, with ripple carry/borrow across all D_NUM digits.
  - Increment: 9 wraps to 0 with carry. The all-9s value wraps to all-0s.
  - Decrement: 0 wraps to 9 with borrow. All-0s wraps to all-9s (e.g. 999999 for D_NUM=6).
- Set=1 at an edge (Rst=0): Out=In, with any In digit >9 loaded as 0.
  - State goes to IDLE with Ready=1 after the edge.
  - A pending BUSY operation is aborted without stepping.
  - Set has priority over a simultaneous Request, which is dropped.
- Set held for several cycles reloads In every cycle and blocks Request acceptance.
- Outputs are registered; there is no combinational path from inputs to Ready/Out.

Test Plan:
- Reset: Rst=1 for 2 clocks, then Rst=0 -> Out=000000, Ready=1; Out stays 000000 with Request=0.
- Latency: COUNT_DELAY=3, Dec=0, one-cycle Request at edge k -> Ready=0 for edges k+1..k+2, Out=000001 and Ready=1 after edge k+3; Request held during BUSY gives no extra step.
- Up/down round trip: tie Request=Ready; 50 steps with Dec=0 -> Out=000050; then 50 steps with Dec=1 -> Out=000000.
- Carry/borrow and wrap: Set In=000099, one up step -> 000100; Set 999999, one up step -> 000000; one down step from 000000 -> 999999; Set 001000, one down step -> 000999.
- Load: Set with In=0x000039 (BCD 39), then 39 down steps -> Out=000000; In digit 0xA loads as 0 (In=0x00001A -> Out=000010).
- Priority and abort: Set asserted mid-BUSY with In=000500 -> Out=000500, Ready=1 next cycle, no step applied; Set and Request on the same edge -> load only; Rst during BUSY -> Out=0, Ready=1.
